prince_round_ctrl: RTL and testbench

- Round sequencer for the round-based threshold-implemented PRINCE core.
- Drives the shared state register, the pipelined TI S-box layer (forward/inverse), the linear-layer mux (M, M', M^-1) and the round-constant index.
- Runs one encryption per start request: load, 5 forward rounds, 2 middle S-layers, 5 inverse rounds, final whitening.
- The datapath holds all key and data shares. This block only issues control.

---
 rtl/prince_round_ctrl.sv | 162 ++++++++++++++++
 tb/tb_prince_round_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/prince_round_ctrl.sv
// prince_round_ctrl
//   Round sequencer for the round-based threshold-implemented PRINCE core.
//   One encryption per accepted start: LOAD, 12 S-layer steps (5 forward
//   rounds, 2 middle S-layers, 5 inverse rounds), FINAL whitening, DONE.
//   The datapath holds all key/data shares; this block only issues control.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start_i     request a new encryption (accepted only while ready_o=1)
//   ready_o     idle, can accept start_i
//   load_o      state register captures input shares ^ k0 ^ k1 ^ RC0
//   sbox_en_o   advance the TI S-box pipeline
//   sbox_inv_o  0: S, 1: S^-1
//   lin_pre_o   0: linear layer/RC/key after S-box, 1: before S-box
//   lin_sel_o   00 none, 01 M, 10 M', 11 M^-1
//   rc_idx_o    round-constant index 0..11
//   state_en_o  state register captures datapath result
//   rand_req_o  request fresh TI randomness (same as sbox_en_o)
//   final_o     apply RC11 ^ k1 and k0' whitening, capture into state
//   done_o      one-cycle pulse: state holds the ciphertext shares
module prince_round_ctrl #(
  parameter int unsigned SBOX_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  output logic       ready_o,
  output logic       load_o,
  output logic       sbox_en_o,
  output logic       sbox_inv_o,
  output logic       lin_pre_o,
  output logic [1:0] lin_sel_o,
  output logic [3:0] rc_idx_o,
  output logic       state_en_o,
  output logic       rand_req_o,
  output logic       final_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    FINAL,
    DONE
  } state_t;

  localparam logic [3:0] LAST_SUB  = 4'(SBOX_LAT - 1);
  localparam logic [3:0] LAST_STEP = 4'd11;

  state_t     state;
  logic [3:0] step_cnt;
  logic [3:0] sub_cnt;

  // Per-step configuration: {sbox_inv, lin_pre, lin_sel[1:0], rc_idx[3:0]}
  function automatic logic [7:0] step_cfg(input logic [3:0] s);
    logic [7:0] cfg;
    if (s < 4'd5)       cfg = {1'b0, 1'b0, 2'b01, s + 4'd1};
    else if (s == 4'd5) cfg = {1'b0, 1'b0, 2'b10, 4'd0};
    else if (s == 4'd6) cfg = {1'b1, 1'b0, 2'b00, 4'd0};
    else                cfg = {1'b1, 1'b1, 2'b11, s - 4'd1};
    return cfg;
  endfunction

  // Outputs are registered: each branch loads the values that belong to
  // the state being entered, so they appear in the same cycle as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      step_cnt   <= '0;
      sub_cnt    <= '0;
      ready_o    <= 1'b1;
      load_o     <= 1'b0;
      sbox_en_o  <= 1'b0;
      sbox_inv_o <= 1'b0;
      lin_pre_o  <= 1'b0;
      lin_sel_o  <= '0;
      rc_idx_o   <= '0;
      state_en_o <= 1'b0;
      rand_req_o <= 1'b0;
      final_o    <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      ready_o    <= 1'b0;
      load_o     <= 1'b0;
      sbox_en_o  <= 1'b0;
      sbox_inv_o <= 1'b0;
      lin_pre_o  <= 1'b0;
      lin_sel_o  <= '0;
      rc_idx_o   <= '0;
      state_en_o <= 1'b0;
      rand_req_o <= 1'b0;
      final_o    <= 1'b0;
      done_o     <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= LOAD;
            load_o     <= 1'b1;
            state_en_o <= 1'b1;
          end else begin
            ready_o <= 1'b1;
          end
        end

        LOAD: begin
          state      <= STEP;
          step_cnt   <= '0;
          sub_cnt    <= '0;
          sbox_en_o  <= 1'b1;
          rand_req_o <= 1'b1;
          {sbox_inv_o, lin_pre_o, lin_sel_o, rc_idx_o} <= step_cfg(4'd0);
          state_en_o <= (LAST_SUB == 4'd0);
        end

        STEP: begin
          if (sub_cnt == LAST_SUB) begin
            if (step_cnt == LAST_STEP) begin
              state      <= FINAL;
              step_cnt   <= '0;
              sub_cnt    <= '0;
              final_o    <= 1'b1;
              state_en_o <= 1'b1;
              rc_idx_o   <= 4'd11;
            end else begin
              step_cnt   <= step_cnt + 4'd1;
              sub_cnt    <= '0;
              sbox_en_o  <= 1'b1;
              rand_req_o <= 1'b1;
              {sbox_inv_o, lin_pre_o, lin_sel_o, rc_idx_o} <= step_cfg(step_cnt + 4'd1);
              state_en_o <= (LAST_SUB == 4'd0);
            end
          end else begin
            sub_cnt    <= sub_cnt + 4'd1;
            sbox_en_o  <= 1'b1;
            rand_req_o <= 1'b1;
            {sbox_inv_o, lin_pre_o, lin_sel_o, rc_idx_o} <= step_cfg(step_cnt);
            state_en_o <= ((sub_cnt + 4'd1) == LAST_SUB);
          end
        end

        FINAL: begin
          state  <= DONE;
          done_o <= 1'b1;
        end

        DONE: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prince_round_ctrl.sv
module tb_prince_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;

  always #5 clk = ~clk;

  // Two builds side by side: SBOX_LAT=3 and SBOX_LAT=1, same stimulus.
  logic       ready3, load3, sben3, sbinv3, pre3, sten3, rand3, fin3, done3;
  logic [1:0] sel3;
  logic [3:0] rc3;
  logic       ready1, load1, sben1, sbinv1, pre1, sten1, rand1, fin1, done1;
  logic [1:0] sel1;
  logic [3:0] rc1;

  prince_round_ctrl #(.SBOX_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start_i(start_i),
    .ready_o(ready3), .load_o(load3), .sbox_en_o(sben3), .sbox_inv_o(sbinv3),
    .lin_pre_o(pre3), .lin_sel_o(sel3), .rc_idx_o(rc3), .state_en_o(sten3),
    .rand_req_o(rand3), .final_o(fin3), .done_o(done3)
  );

  prince_round_ctrl #(.SBOX_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start_i),
    .ready_o(ready1), .load_o(load1), .sbox_en_o(sben1), .sbox_inv_o(sbinv1),
    .lin_pre_o(pre1), .lin_sel_o(sel1), .rc_idx_o(rc1), .state_en_o(sten1),
    .rand_req_o(rand1), .final_o(fin1), .done_o(done1)
  );

  // Packed view: {ready, load, sbox_en, sbox_inv, lin_pre, lin_sel, rc_idx,
  //               state_en, rand_req, final, done}
  logic [14:0] obs3, obs1;
  assign obs3 = {ready3, load3, sben3, sbinv3, pre3, sel3, rc3, sten3, rand3, fin3, done3};
  assign obs1 = {ready1, load1, sben1, sbinv1, pre1, sel1, rc1, sten1, rand1, fin1, done1};

  int vectors = 0;
  int miscompares = 0;

  // Model state: cycles elapsed since the accepting edge (0 = idle).
  int c3 = 0;
  int c1 = 0;

  // Expected outputs in operation cycle c for a given S-box latency.
  function automatic logic [14:0] model_out(input int c, input int lat);
    logic       ready, load, sben, inv, pre, sten, rnd, fin, dn;
    logic [1:0] sel;
    logic [3:0] rc;
    int s, sub;
    ready = 0; load = 0; sben = 0; inv = 0; pre = 0; sten = 0;
    rnd = 0; fin = 0; dn = 0; sel = 2'b00; rc = 4'd0;
    if (c == 0) begin
      ready = 1;
    end else if (c == 1) begin
      load = 1; sten = 1;
    end else if (c <= 12 * lat + 1) begin
      s   = (c - 2) / lat;
      sub = (c - 2) % lat;
      sben = 1; rnd = 1;
      sten = (sub == lat - 1);
      inv  = (s >= 6);
      pre  = (s >= 7);
      if (s < 5)       sel = 2'b01;
      else if (s == 5) sel = 2'b10;
      else if (s == 6) sel = 2'b00;
      else             sel = 2'b11;
      if (s < 5)      rc = 4'(s + 1);
      else if (s < 7) rc = 4'd0;
      else            rc = 4'(s - 1);
    end else if (c == 12 * lat + 2) begin
      fin = 1; sten = 1; rc = 4'd11;
    end else begin
      dn = 1;
    end
    return {ready, load, sben, inv, pre, sel, rc, sten, rnd, fin, dn};
  endfunction

  function automatic int model_next(input int c, input int lat, input logic st, input logic r);
    if (r) return 0;
    if (c == 0) return st ? 1 : 0;
    if (c == 12 * lat + 3) return 0;
    return c + 1;
  endfunction

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive start, advance model at the edge, compare at negedge.
  task automatic run_cycle(input logic st);
    logic r;
    start_i = st;
    @(posedge clk);
    r  = rst;
    c3 = model_next(c3, 3, st, r);
    c1 = model_next(c1, 1, st, r);
    @(negedge clk);
    check("lat3", obs3, model_out(c3, 3));
    check("lat1", obs1, model_out(c1, 1));
  endtask

  // Assert reset between edges and check that outputs clear immediately.
  task automatic async_reset(input int hold_cycles);
    #2 rst = 1'b1;
    #1;
    c3 = 0;
    c1 = 0;
    check("async_rst3", obs3, model_out(0, 3));
    check("async_rst1", obs1, model_out(0, 1));
    for (int i = 0; i < hold_cycles; i++) run_cycle(1'b0);
    rst = 1'b0;
  endtask

  int lat_cnt, first_done3, first_done1, done3_cnt;

  initial begin
    // Reset state
    repeat (3) run_cycle(1'b0);
    rst = 1'b0;
    run_cycle(1'b0);

    // Single start pulse, with ignored pulses at cycles 10 and 20
    run_cycle(1'b1);
    for (int i = 2; i <= 50; i++) run_cycle(i == 10 || i == 20);

    // Explicit latency: done at 39 (lat 3) and 15 (lat 1), one done only
    first_done3 = 0; first_done1 = 0; done3_cnt = 0;
    run_cycle(1'b1);
    lat_cnt = 1;
    while (lat_cnt < 100 && first_done3 == 0) begin
      run_cycle((lat_cnt == 9) || (lat_cnt == 19));
      lat_cnt++;
      if (done1 && first_done1 == 0) first_done1 = lat_cnt;
      if (done3) begin first_done3 = lat_cnt; done3_cnt++; end
    end
    check_int("latency_lat3", first_done3, 39);
    check_int("latency_lat1", first_done1, 15);
    repeat (10) begin
      run_cycle(1'b0);
      if (done3) done3_cnt++;
    end
    check_int("single_done", done3_cnt, 1);

    // start held high for 100 cycles (back-to-back runs)
    for (int i = 0; i < 100; i++) run_cycle(1'b1);
    repeat (50) run_cycle(1'b0);

    // Async reset mid-clock at cycle 15, then a full run
    run_cycle(1'b1);
    for (int i = 2; i <= 15; i++) run_cycle(1'b0);
    async_reset(2);
    repeat (3) run_cycle(1'b0);
    run_cycle(1'b1);
    for (int i = 2; i <= 45; i++) run_cycle(1'b0);

    // Randomised starts with occasional async resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset($urandom_range(0, 2));
      else run_cycle($urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
